// File: rtl/mem_access_unit.sv
// MEM stage bus adapter: sub-word load/store formatting, byte enables, alignment
// checks and a single-outstanding req/ack handshake with timeout abort.
module mem_access_unit #(
  parameter int W           = 32,
  parameter int OFS         = $clog2(W/8),
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_en,
  input  logic             mem_write_en,
  input  logic [1:0]       mem_size,
  input  logic             mem_unsigned,
  input  logic [W-1:0]     mem_addr,
  input  logic [W-1:0]     mem_write_data,
  output logic [W-1:0]     mem_read_data,
  output logic             mem_stall,
  output logic             addr_err,
  output logic             bus_timeout,
  output logic             bus_req,
  output logic             bus_we,
  output logic [W-1:0]     bus_addr,
  output logic [W-1:0]     bus_wdata,
  output logic [W/8-1:0]   bus_be,
  input  logic [W-1:0]     bus_rdata,
  input  logic             bus_ack
);

  localparam int NB = W/8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [15:0] CNT_LIM = 16'(TIMEOUT_CYC - 1);

  typedef struct packed {
    logic [1:0]     size;
    logic           uns;
    logic [OFS-1:0] off;
  } acc_t;

  logic [1:0]          state;
  acc_t                acc_q;
  logic [15:0]         cnt;
  logic                en, mis, size_ok, acc_valid;
  logic [NB-1:0]       be_base, be_c;
  logic [NB-1:0][7:0]  wd_b, wd_lanes;

  // ---- request decode ----
  assign en      = mem_read_en | mem_write_en;
  assign size_ok = (mem_size != 2'b11) || (W == 64);

  always_comb begin
    mis = 1'b0;
    case (mem_size)
      2'b01:   mis = mem_addr[0];
      2'b10:   mis = |mem_addr[1:0];
      2'b11:   mis = |mem_addr[2:0];
      default: mis = 1'b0;
    endcase
  end

  assign addr_err  = en & (~size_ok | mis);
  assign acc_valid = en & ~addr_err;
  assign mem_stall = (state == S_REQ) | ((state == S_IDLE) & acc_valid);
  assign bus_req   = (state == S_REQ);

  always_comb begin
    be_base = '0;
    case (mem_size)
      2'b00:   be_base[0]   = 1'b1;
      2'b01:   be_base[1:0] = 2'b11;
      2'b10:   be_base[3:0] = 4'hF;
      default: be_base      = '1;
    endcase
    be_c = be_base << mem_addr[OFS-1:0];
  end

  // Each byte lane takes the store byte that lands there after replication.
  assign wd_b = mem_write_data;
  for (genvar gl = 0; gl < NB; gl++) begin : g_lane
    always_comb begin
      case (mem_size)
        2'b00:   wd_lanes[gl] = wd_b[0];
        2'b01:   wd_lanes[gl] = wd_b[gl % 2];
        2'b10:   wd_lanes[gl] = wd_b[gl % 4];
        default: wd_lanes[gl] = wd_b[gl];
      endcase
    end
  end

  function automatic logic [W-1:0] fmt_load(input logic [W-1:0] rd, input acc_t a);
    logic [W-1:0] sh, res;
    sh  = rd >> {a.off, 3'b000};
    res = sh;
    case (a.size)
      2'b00: begin res = {W{~a.uns & sh[7]}};  res[7:0]  = sh[7:0];  end
      2'b01: begin res = {W{~a.uns & sh[15]}}; res[15:0] = sh[15:0]; end
      2'b10: begin res = {W{~a.uns & sh[31]}}; res[31:0] = sh[31:0]; end
      default: res = sh;
    endcase
    return res;
  endfunction

  // ---- handshake FSM ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      acc_q         <= '0;
      cnt           <= '0;
      mem_read_data <= '0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_be        <= '0;
      bus_timeout   <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      case (state)
        S_IDLE: if (acc_valid) begin
          acc_q     <= '{size: mem_size, uns: mem_unsigned, off: mem_addr[OFS-1:0]};
          bus_we    <= mem_write_en & ~mem_read_en;
          bus_addr  <= {mem_addr[W-1:OFS], {OFS{1'b0}}};
          bus_be    <= be_c;
          bus_wdata <= wd_lanes;
          cnt       <= '0;
          state     <= S_REQ;
        end
        S_REQ: begin
          // Ack on the limit cycle still completes normally.
          if (bus_ack) begin
            if (!bus_we) mem_read_data <= fmt_load(bus_rdata, acc_q);
            state <= S_DONE;
          end else if (cnt == CNT_LIM) begin
            bus_timeout   <= 1'b1;
            mem_read_data <= '0;
            state         <= S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (W=32, TIMEOUT_CYC=4): per-cycle compare
// against a transaction-level model plus literal spot checks.
module tb_mem_access_unit;
  localparam int W  = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_read_en, mem_write_en, mem_unsigned;
  logic [1:0]    mem_size;
  logic [W-1:0]  mem_addr, mem_write_data, mem_read_data;
  logic          mem_stall, addr_err, bus_timeout, bus_req, bus_we, bus_ack;
  logic [W-1:0]  bus_addr, bus_wdata, bus_rdata;
  logic [W/8-1:0] bus_be;

  mem_access_unit #(.W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_stall(mem_stall),
    .addr_err(addr_err), .bus_timeout(bus_timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // ---- model: spec rules as plain arithmetic ----
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                         input bit uns, input int off);
    logic [63:0] v;
    int nb;
    nb = 1 << sz;
    v  = 64'(rd >> (8 * off));
    v  = v & ((64'd1 << (8 * nb)) - 64'd1);
    if (!uns && v[8 * nb - 1]) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input int off);
    int nb;
    nb = 1 << sz;
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int nb;
    nb = 1 << sz;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(d >> (8 * (k % nb)));
    return r;
  endfunction

  logic        e_stall, e_req, e_err, e_to, e_bus, e_we, e_wdck;
  logic [31:0] e_rd, e_addr, e_wd, mdl_rd;
  logic [3:0]  e_be;
  bit          chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_stall", mem_stall, e_stall);
      chk("bus_req", bus_req, e_req);
      chk("addr_err", addr_err, e_err);
      chk("bus_timeout", bus_timeout, e_to);
      chk("mem_read_data", mem_read_data, e_rd);
      if (e_bus) begin
        chk("bus_we", bus_we, e_we);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", bus_be, e_be);
        if (e_wdck) chk("bus_wdata", bus_wdata, e_wd);
      end
    end
  end

  task automatic set_idle_exp();
    e_stall = 0; e_req = 0; e_err = 0; e_to = 0; e_bus = 0; e_rd = mdl_rd;
  endtask

  // ack_at: REQ cycle (1-based) in which ack is driven; 0 = never (timeout)
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_at, input logic [31:0] rdata);
    int n, off;
    bit is_rd;
    is_rd = rd;
    off   = int'(addr[1:0]);
    n     = (ack_at == 0) ? TO : ack_at;
    @(posedge clk); #1;
    mem_read_en = rd; mem_write_en = wr; mem_size = sz; mem_unsigned = uns;
    mem_addr = addr; mem_write_data = wd; bus_ack = 0;
    set_idle_exp(); e_stall = 1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      e_stall = 1; e_req = 1; e_bus = 1; e_we = !is_rd; e_wdck = !is_rd;
      e_addr = addr & 32'hFFFF_FFFC; e_be = m_be(sz, off); e_wd = m_wd(sz, wd);
      bus_ack = (c == ack_at); bus_rdata = rdata;
    end
    @(posedge clk); #1;
    bus_ack = 0; bus_rdata = 32'h5555_AAAA;
    if (ack_at == 0) mdl_rd = 0;
    else if (is_rd) mdl_rd = m_load(rdata, sz, uns, off);
    set_idle_exp(); e_to = (ack_at == 0);
    @(posedge clk); #1;
    mem_read_en = 0; mem_write_en = 0;
    set_idle_exp();
  endtask

  task automatic err_case(input logic [1:0] sz, input logic [31:0] addr);
    @(posedge clk); #1;
    mem_read_en = 1; mem_size = sz; mem_addr = addr;
    set_idle_exp(); e_err = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_read_en = 0;
    set_idle_exp();
  endtask

  initial begin
    rst_n = 0; mem_read_en = 0; mem_write_en = 0; mem_size = 0; mem_unsigned = 0;
    mem_addr = 0; mem_write_data = 0; bus_ack = 0; bus_rdata = 0;
    mdl_rd = 0; e_wdck = 0; e_we = 0; e_addr = 0; e_wd = 0; e_be = 0;
    set_idle_exp();
    chk_en = 1;
    #2;
    chk("reset bus_be", bus_be, 0);
    chk("reset bus_addr", bus_addr, 0);
    chk("reset bus_wdata", bus_wdata, 0);
    chk("reset bus_we", bus_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    access(1, 0, 2'b10, 0, 32'h100, 0, 3, 32'hDEAD_BEEF);
    chk("lw data", mem_read_data, 32'hDEAD_BEEF);
    access(1, 0, 2'b00, 0, 32'h103, 0, 1, 32'h80FF_FF12);
    chk("lb signed", mem_read_data, 32'hFFFF_FF80);
    access(1, 0, 2'b00, 1, 32'h103, 0, 1, 32'h80FF_FF12);
    chk("lbu", mem_read_data, 32'h0000_0080);
    access(1, 0, 2'b01, 0, 32'h102, 0, 2, 32'h8001_1234);
    chk("lh signed", mem_read_data, 32'hFFFF_8001);
    access(1, 0, 2'b01, 1, 32'h100, 0, 1, 32'h8001_1234);
    chk("lhu", mem_read_data, 32'h0000_1234);
    access(0, 1, 2'b01, 0, 32'h202, 32'h0000_ABCD, 1, 32'hFFFF_FFFF);
    chk("sh wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh be", bus_be, 4'b1100);
    chk("sh rdata kept", mem_read_data, 32'h0000_1234);
    access(0, 1, 2'b00, 0, 32'h301, 32'h0000_005A, 2, 32'h0);
    chk("sb wdata", bus_wdata, 32'h5A5A_5A5A);
    access(1, 1, 2'b10, 0, 32'h400, 32'h1111_1111, 1, 32'h1234_5678);
    chk("rd+wr is read", mem_read_data, 32'h1234_5678);

    err_case(2'b10, 32'h101);
    err_case(2'b11, 32'h100);
    err_case(2'b01, 32'h103);
    chk("err rdata kept", mem_read_data, 32'h1234_5678);

    access(1, 0, 2'b10, 0, 32'h500, 0, 0, 32'h0);
    chk("timeout rdata", mem_read_data, 32'h0);
    access(1, 0, 2'b10, 0, 32'h504, 0, TO, 32'hCAFE_F00D);
    chk("ack at limit", mem_read_data, 32'hCAFE_F00D);

    // reset in the middle of an access
    chk_en = 0;
    @(posedge clk); #1;
    mem_read_en = 1; mem_size = 2'b10; mem_addr = 32'h600;
    @(posedge clk); #1;
    chk("req before reset", bus_req, 1);
    @(posedge clk); #3;
    rst_n = 0; mem_read_en = 0;
    #1;
    chk("req async drop", bus_req, 0);
    chk("stall after reset", mem_stall, 0);
    chk("rdata after reset", mem_read_data, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    chk("stray ack req", bus_req, 0);
    chk("stray ack rdata", mem_read_data, 0);
    bus_ack = 0;
    mdl_rd = 0;
    set_idle_exp();
    chk_en = 1;

    access(1, 0, 2'b00, 1, 32'h0, 0, 1, 32'h0000_007F);
    chk("lbu after reset", mem_read_data, 32'h0000_007F);

    @(posedge clk); #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the pass-through MEM stage.
- Sits between EX/MEM pipeline register and the data-bus port; adds sub-word loads/stores, byte enables, sign/zero extension, misalignment detection, a req/ack handshake to a variable-latency memory, pipeline stall generation and a bus timeout.
- One access in flight at a time.

Parameters:
- W, 32, data/address width; legal values 32 or 64.
- OFS, $clog2(W/8), byte-offset bits in the address (derived; not overridden).
- TIMEOUT_CYC, 255, max cycles in REQ without ack before abort; range 1..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read_en  in  1  load request from pipeline.
- mem_write_en  in  1  store request from pipeline.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 dword (W=64 only).
- mem_unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- mem_addr  in  W  byte address (ALU result).
- mem_write_data  in  W  store data, right-justified.
- mem_read_data  out  W  formatted load result, registered.
- mem_stall  out  1  hold upstream pipeline.
- addr_err  out  1  misaligned or illegal size, combinational.
- bus_timeout  out  1  one-cycle pulse on abort.
- bus_req  out  1  request to memory.
- bus_we  out  1  1 = write.
- bus_addr  out  W  address with low OFS bits forced 0.
- bus_wdata  out  W  lane-replicated store data.
- bus_be  out  W/8  byte enables; lane k = byte address offset k (little-endian).
- bus_rdata  in  W  read data, valid with ack.
- bus_ack  in  1  completion; only sampled in REQ.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_read_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0, bus_timeout=0, timeout counter=0. mem_stall and addr_err follow their combinational equations with state=IDLE. Reset during REQ drops bus_req immediately; the access is abandoned and never completes.
- Access valid = (mem_read_en | mem_write_en) & ~addr_err.
- Both enables high: treated as a read; the store is ignored.
- addr_err = enable & (size illegal for W, or half with addr[0]!=0, or word with addr[1:0]!=0, or dword with addr[2:0]!=0).
- On addr_err: no bus access, no stall, mem_read_data unchanged. The exception path is the pipeline's responsibility.
- States: IDLE, REQ, DONE.
- IDLE:
  - Valid access: mem_stall=1 combinationally. Latch bus_addr, bus_we, bus_be, bus_wdata, size and unsigned flag. Clear counter. Go to REQ.
  - Otherwise stay in IDLE, mem_stall=0.
- REQ: bus_req=1, mem_stall=1, counter increments each cycle.
  - bus_ack=1: for a read, register the formatted bus_rdata into mem_read_data; for a write, mem_read_data is unchanged. Go to DONE.
  - Counter reaches TIMEOUT_CYC-1 without ack: bus_timeout=1 next cycle, mem_read_data=0, go to DONE.
  - Ack in the same cycle as the timeout limit: ack wins, no timeout.
- DONE: bus_req=0, mem_stall=0 for exactly one cycle, so the pipeline advances. Inputs are ignored (they still show the completed instruction). Go to IDLE.
- Minimum access latency: IDLE -> REQ (ack same cycle) -> DONE = 3 cycles, of which 2 are stalled.
- Store lanes: byte data replicated to all lanes, half to every 2-byte lane, word to every 4-byte lane.
- bus_be: 1 bit (byte), 2 bits (half), 4 bits (word) or all bits (dword), shifted left by addr[OFS-1:0].
- Load format: extract the lane selected by the offset, then sign- or zero-extend to W. Word on W=64 extends per mem_unsigned; dword is passed unchanged.
- bus_ack outside REQ is ignored.

Test Plan:
- W=32, LW addr 0x100, ack after 3 REQ cycles with rdata 0xDEADBEEF -> bus_addr 0x100, bus_be 1111, mem_stall high 4 cycles, mem_read_data 0xDEADBEEF in DONE.
- LB signed addr 0x103, rdata 0x80FF_FF12 -> bus_be 1000, mem_read_data 0xFFFFFF80; same access with LBU -> 0x00000080.
- SH addr 0x202, data 0x0000ABCD, ack immediately -> bus_we=1, bus_be 1100, bus_wdata 0xABCDABCD, mem_read_data unchanged, 2 stall cycles.
- LW addr 0x101 -> addr_err=1 same cycle, bus_req never asserts, mem_stall=0; size 11 on W=32 -> addr_err=1.
- TIMEOUT_CYC=4, read with no ack -> bus_req high exactly 4 cycles, bus_timeout 1-cycle pulse, mem_read_data=0, back to IDLE; ack in the 4th cycle -> no timeout.
- rst_n low during REQ -> bus_req drops asynchronously, state IDLE; a later ack is ignored.
